frame_cell_ram: RTL and testbench

Single-clock, dual-port pixel store for one 640×480 frame of 3-bit pixels, addressed by (x, y) coordinates.
- One write port (renderer side) and one independent synchronous read port (display/scan-out side) operate every cycle.
- Sits between the pixel generator and the VGA scan-out logic in the frame buffer.

---
 rtl/frame_pkg.sv | 28 ++
 rtl/frame_cell_ram_if.sv | 29 ++
 rtl/frame_ram.sv | 33 +++
 rtl/frame_cell_ram.sv | 60 ++++++
 tb/tb_frame_cell_ram.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// Shared frame geometry, pixel/coordinate types and the (x,y) -> linear
// address helper used by both ports of the frame store.
package frame_pkg;

  localparam int FRAME_WIDTH  = 640;
  localparam int FRAME_HEIGHT = 480;
  localparam int PIXEL_BITS   = 3;
  localparam int X_BITS       = 10;
  localparam int Y_BITS       = 9;
  localparam int ADDR_BITS    = 19;
  localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

  typedef logic [PIXEL_BITS-1:0] pixel_t;
  typedef logic [X_BITS-1:0]     xcoord_t;
  typedef logic [Y_BITS-1:0]     ycoord_t;
  typedef logic [ADDR_BITS-1:0]  addr_t;

  // y*640 + x as two shifts and adds: 640 = 512 + 128, so no multiplier.
  // The shift amounts are tied to the 640-pixel line length.
  function automatic addr_t xy_to_addr(input xcoord_t x, input ycoord_t y);
    addr_t ye;
    addr_t xe;
    ye = addr_t'(y);
    xe = addr_t'(x);
    return (ye << 9) + (ye << 7) + xe;
  endfunction

endpackage

// File: rtl/frame_cell_ram_if.sv
// Renderer write port and scan-out read port of the frame store.
// master = pixel generator / scan-out side, slave = the frame store.
interface frame_cell_ram_if #(
  parameter int X_BITS     = frame_pkg::X_BITS,
  parameter int Y_BITS     = frame_pkg::Y_BITS,
  parameter int PIXEL_BITS = frame_pkg::PIXEL_BITS
);

  logic [X_BITS-1:0]     write_frame_width;
  logic [Y_BITS-1:0]     write_frame_height;
  logic                  write_enable;
  logic [PIXEL_BITS-1:0] write_data;
  logic [X_BITS-1:0]     read_frame_width;
  logic [Y_BITS-1:0]     read_frame_height;
  logic [PIXEL_BITS-1:0] read_data;

  modport master (
    output write_frame_width, write_frame_height, write_enable, write_data,
    output read_frame_width, read_frame_height,
    input  read_data
  );

  modport slave (
    input  write_frame_width, write_frame_height, write_enable, write_data,
    input  read_frame_width, read_frame_height,
    output read_data
  );

endinterface

// File: rtl/frame_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
// No reset and no initial contents so synthesis maps it onto block RAM.
module frame_ram
  import frame_pkg::*;
#(
  parameter int DEPTH  = FRAME_PIXELS,
  parameter int DATA_W = PIXEL_BITS,
  parameter int ADDR_W = ADDR_BITS
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // read port; sampling in the same edge as the write gives old data (read-first)
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_cell_ram.sv
// One-frame pixel store addressed by (x,y). Converts both coordinate pairs to
// linear addresses, drops out-of-frame writes, and forces read_data to zero
// for out-of-frame reads and while reset is asserted. Memory survives reset.
module frame_cell_ram #(
  parameter int FRAME_WIDTH  = frame_pkg::FRAME_WIDTH,
  parameter int FRAME_HEIGHT = frame_pkg::FRAME_HEIGHT,
  parameter int PIXEL_BITS   = frame_pkg::PIXEL_BITS,
  parameter int X_BITS       = frame_pkg::X_BITS,
  parameter int Y_BITS       = frame_pkg::Y_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  frame_cell_ram_if.slave  bus
);

  localparam logic [X_BITS-1:0] X_LIM = X_BITS'(FRAME_WIDTH);
  localparam logic [Y_BITS-1:0] Y_LIM = Y_BITS'(FRAME_HEIGHT);

  logic                    w_wr_in;
  logic                    w_rd_in;
  logic                    w_we;
  frame_pkg::addr_t        w_wr_addr;
  frame_pkg::addr_t        w_rd_addr;
  logic [PIXEL_BITS-1:0]   w_ram_q;
  logic                    r_rd_vld;

  assign w_wr_in = (bus.write_frame_width < X_LIM) && (bus.write_frame_height < Y_LIM);
  assign w_rd_in = (bus.read_frame_width  < X_LIM) && (bus.read_frame_height  < Y_LIM);

  // Out-of-frame coordinates are parked on address 0 so the RAM index never
  // leaves the array; the write is gated off and the read result is masked.
  assign w_wr_addr = w_wr_in ? frame_pkg::xy_to_addr(bus.write_frame_width, bus.write_frame_height) : '0;
  assign w_rd_addr = w_rd_in ? frame_pkg::xy_to_addr(bus.read_frame_width,  bus.read_frame_height)  : '0;

  // Writes are blocked while reset is held.
  assign w_we = bus.write_enable && w_wr_in && rst_n;

  frame_ram #(
    .DEPTH  (FRAME_WIDTH * FRAME_HEIGHT),
    .DATA_W (PIXEL_BITS),
    .ADDR_W (frame_pkg::ADDR_BITS)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wdata (bus.write_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_ram_q)
  );

  // Tracks whether the RAM output register holds an in-frame read; the async
  // clear zeroes read_data the moment reset asserts without touching the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_vld <= 1'b0;
    else        r_rd_vld <= w_rd_in;
  end

  assign bus.read_data = r_rd_vld ? w_ram_q : '0;

endmodule

// File: tb/tb_frame_cell_ram.sv
// Directed bench for frame_cell_ram: partial raster fill and read-back,
// a table of port vectors with hand-computed results, and a reset sequence.
module tb_frame_cell_ram;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  frame_cell_ram_if bus ();

  frame_cell_ram dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit we;
    int wx, wy, wd;
    int rx, ry;
    bit chk;
    int exp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit we, int wx, int wy, int wd, int rx, int ry, bit chk, int exp);
    vec_t v;
    v.we = we; v.wx = wx; v.wy = wy; v.wd = wd;
    v.rx = rx; v.ry = ry; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input bit we, input int wx, input int wy, input int wd,
                       input int rx, input int ry);
    bus.write_enable       = we;
    bus.write_frame_width  = 10'(wx);
    bus.write_frame_height = 9'(wy);
    bus.write_data         = 3'(wd);
    bus.read_frame_width   = 10'(rx);
    bus.read_frame_height  = 9'(ry);
  endtask

  task automatic check(input string nm, input logic [2:0] got, input int exp);
    n_cmp++;
    if (got !== 3'(exp)) begin
      n_err++;
      $display("FAIL %s: read_data=%0d expected=%0d", nm, got, exp);
    end
  endtask

  initial begin
    int rows[5] = '{0, 1, 2, 240, 479};

    // reset state
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1 check("reset_state", bus.read_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // raster fill of a handful of lines with (x+y) mod 8
    foreach (rows[r]) begin
      for (int x = 0; x < 640; x++) begin
        drive(1, x, rows[r], (x + rows[r]) % 8, 700, 500);
        @(negedge clk);
      end
    end
    // raster read-back, one cycle per pixel
    foreach (rows[r]) begin
      for (int x = 0; x < 640; x++) begin
        drive(0, 0, 0, 0, x, rows[r]);
        @(negedge clk);
        check($sformatf("fill(%0d,%0d)", x, rows[r]), bus.read_data, (x + rows[r]) % 8);
      end
    end

    // vector table: {we, wx, wy, wd, rx, ry, chk, exp}
    vt.push_back(mk(1,   11,  20, 2,  700, 500, 1, 0)); // out-of-frame read
    vt.push_back(mk(1,   10,  20, 5,  639, 480, 1, 0)); // y just out
    vt.push_back(mk(0,    0,   0, 0,   10,  20, 1, 5)); // write->read next edge
    vt.push_back(mk(0,    0,   0, 0,   11,  20, 1, 2)); // address change
    vt.push_back(mk(1,    5,   5, 3,  640, 479, 1, 0)); // x just out
    vt.push_back(mk(1,    5,   5, 6,    5,   5, 1, 3)); // read-first
    vt.push_back(mk(0,    0,   0, 0,    5,   5, 1, 6)); // new value next read
    vt.push_back(mk(1,    0,   0, 1, 1023, 511, 1, 0));
    vt.push_back(mk(1,  639,   0, 4,    0,   0, 1, 1)); // corner (0,0)
    vt.push_back(mk(1,    0, 479, 2,  639,   0, 1, 4)); // corner (639,0)
    vt.push_back(mk(1,  639, 479, 7,    0, 479, 1, 2)); // corner (0,479)
    vt.push_back(mk(1,    0,   1, 3,  639, 479, 1, 7)); // corner (639,479)
    vt.push_back(mk(1,    1,   1, 4,    0,   1, 1, 3));
    vt.push_back(mk(1,  640,   0, 7,    1,   1, 1, 4)); // (640,0) would alias (0,1)
    vt.push_back(mk(1,    0, 480, 7,    0,   1, 1, 3));
    vt.push_back(mk(1, 1023, 511, 7,    0,   0, 1, 1));
    vt.push_back(mk(0,    0,   0, 0,  639, 479, 1, 7));
    vt.push_back(mk(0,    0,   0, 0,    0,   1, 1, 3));
    vt.push_back(mk(0,    0,   0, 0,    2,   0, 1, 2)); // fill data untouched
    vt.push_back(mk(0,    0,   0, 0,  300, 240, 1, 4));
    vt.push_back(mk(0,    0,   0, 0,  639,   2, 1, 1));
    vt.push_back(mk(0,    0,   0, 0,  638, 479, 1, 5));

    foreach (vt[i]) begin
      drive(vt[i].we, vt[i].wx, vt[i].wy, vt[i].wd, vt[i].rx, vt[i].ry);
      @(negedge clk);
      if (vt[i].chk) check($sformatf("vec[%0d]", i), bus.read_data, vt[i].exp);
    end

    // reset mid-read: output clears at once, writes blocked, memory kept
    drive(0, 0, 0, 0, 10, 20);
    @(negedge clk);
    check("pre_reset_read", bus.read_data, 5);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", bus.read_data, 0);
    drive(1, 1, 1, 7, 1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("held_reset[%0d]", k), bus.read_data, 0);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 1);
    @(negedge clk);
    check("post_reset(1,1)", bus.read_data, 4);
    drive(0, 0, 0, 0, 10, 20);
    @(negedge clk);
    check("post_reset(10,20)", bus.read_data, 5);
    drive(0, 0, 0, 0, 639, 479);
    @(negedge clk);
    check("post_reset(639,479)", bus.read_data, 7);
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    check("post_reset(0,1)", bus.read_data, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
